// File: rtl/demux2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : demux2_pkg                                                    |
// | Brief    : Shared types and select encodings for the demux2_stream block |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package demux2_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/demux2_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : demux2_stream_if                                              |
// | Brief    : Producer and two-consumer handshake bundle for demux2_stream  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface demux2_stream_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  // Environment side: drives the producer and both consumer ready lines.
  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

endinterface
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : demux_slot                                                    |
// | Brief    : One-entry registered output slot with optional saturating     |
// |            transfer counter (enabled by DEMUX2_CNT_EN)                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module demux_slot #(
  parameter int WIDTH = 32
`ifdef DEMUX2_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept_i,
  input  logic             out_ready_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             empty_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
`ifdef DEMUX2_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_o
`endif
);

  import demux2_pkg::*;

  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (accept_i) begin
          state_d = SLOT_FULL;
          data_d  = data_i;
        end
      end
      SLOT_FULL: begin
        // A new accept in the drain cycle refills the slot without a bubble.
        if (accept_i) begin
          data_d = data_i;
        end else if (out_ready_i) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  assign empty_o = (state_q == SLOT_EMPTY);
  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

`ifdef DEMUX2_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule
`default_nettype wire

// File: rtl/demux2_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : demux2_stream                                                 |
// | Brief    : One-input, two-output stream demultiplexer with a registered  |
// |            slot per output; per-output counters with DEMUX2_CNT_EN       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module demux2_stream #(
  parameter int WIDTH = 32
`ifdef DEMUX2_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  demux2_stream_if.slave   bus
`ifdef DEMUX2_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  import demux2_pkg::*;

  logic w_empty0, w_empty1;
  logic w_ready0, w_ready1;
  logic w_accept0, w_accept1;

  // in_ready looks only at the addressed slot, so a stalled sink never blocks the other.
  assign w_ready0     = w_empty0 | bus.out0_ready;
  assign w_ready1     = w_empty1 | bus.out1_ready;
  assign bus.in_ready = (bus.in_sel == SEL_OUT1) ? w_ready1 : w_ready0;

  assign w_accept0 = bus.in_valid & bus.in_ready & (bus.in_sel == SEL_OUT0);
  assign w_accept1 = bus.in_valid & bus.in_ready & (bus.in_sel == SEL_OUT1);

  demux_slot #(
    .WIDTH       (WIDTH)
`ifdef DEMUX2_CNT_EN
    ,
    .CNT_W       (CNT_W)
`endif
  ) u_slot0 (
    .clk         (clk),
    .rst         (rst),
    .accept_i    (w_accept0),
    .out_ready_i (bus.out0_ready),
    .data_i      (bus.in_data),
    .empty_o     (w_empty0),
    .valid_o     (bus.out0_valid),
    .data_o      (bus.out0_data)
`ifdef DEMUX2_CNT_EN
    ,
    .cnt_o       (cnt0)
`endif
  );

  demux_slot #(
    .WIDTH       (WIDTH)
`ifdef DEMUX2_CNT_EN
    ,
    .CNT_W       (CNT_W)
`endif
  ) u_slot1 (
    .clk         (clk),
    .rst         (rst),
    .accept_i    (w_accept1),
    .out_ready_i (bus.out1_ready),
    .data_i      (bus.in_data),
    .empty_o     (w_empty1),
    .valid_o     (bus.out1_valid),
    .data_o      (bus.out1_data)
`ifdef DEMUX2_CNT_EN
    ,
    .cnt_o       (cnt1)
`endif
  );

endmodule
`default_nettype wire
